// File: rtl/vend_pkg.sv
// Shared types, coin encodings and coin valuation for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    PAYOUT  = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;
  localparam logic [1:0] COIN_200  = 2'b11;

  // Coin code to value in kurus.
  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_50:  return 8'd50;
      COIN_100: return 8'd100;
      COIN_200: return 8'd200;
      default:  return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item saturating stock counters with sold-out decode.
module vend_stock
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int SEL_W      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec,
  input  logic [SEL_W-1:0]   dec_sel,
  input  logic               inc,
  input  logic [SEL_W-1:0]   inc_sel,
  output logic [N_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] cnt [N_ITEMS];

  // Stock update: a simultaneous increment and decrement of one item cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) cnt[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        if (inc && inc_sel == SEL_W'(i) && !(dec && dec_sel == SEL_W'(i))) begin
          if (cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
        end else if (dec && dec_sel == SEL_W'(i) && !(inc && inc_sel == SEL_W'(i))) begin
          if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Sold-out flags decoded from the stock registers.
  always_comb begin
    sold_out = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) sold_out[i] = (cnt[i] == '0);
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin collection, vend, refund and acknowledged payout.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                         N_ITEMS    = 4,
  parameter int                         BAL_W      = 10,
  parameter int                         MAX_BAL    = 500,
  parameter logic [N_ITEMS*BAL_W-1:0]   PRICES     = {10'd100, 10'd200, 10'd250, 10'd150},
  parameter int                         STOCK_W    = 4,
  parameter int                         STOCK_INIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 coin,
  input  logic [$clog2(N_ITEMS)-1:0] sel,
  input  logic                       dispense,
  input  logic                       cancel,
  input  logic                       restock,
  input  logic [$clog2(N_ITEMS)-1:0] restock_sel,
  input  logic                       change_ack,
  output logic [BAL_W-1:0]           balance,
  output logic [BAL_W-1:0]           change,
  output logic                       change_valid,
  output logic [N_ITEMS-1:0]         vend,
  output logic                       coin_reject,
  output logic                       err_funds,
  output logic                       err_soldout,
  output logic [N_ITEMS-1:0]         sold_out
);

  localparam int SEL_W = $clog2(N_ITEMS);

  state_t             state, state_d;
  logic [BAL_W-1:0]   balance_d, change_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               coin_reject_d, err_funds_d, err_soldout_d;
  logic [BAL_W:0]     coin_sum;
  logic [BAL_W-1:0]   price_sel, price_q;

  assign coin_sum  = {1'b0, balance} + (BAL_W+1)'(coin_value(coin));
  assign price_sel = PRICES[sel*BAL_W +: BAL_W];
  assign price_q   = PRICES[sel_q*BAL_W +: BAL_W];

  vend_stock #(
    .N_ITEMS    (N_ITEMS),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT),
    .SEL_W      (SEL_W)
  ) u_stock (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec      (state == VEND),
    .dec_sel  (sel_q),
    .inc      (restock),
    .inc_sel  (restock_sel),
    .sold_out (sold_out)
  );

  // State, credit, payout and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= COLLECT;
      balance     <= '0;
      change      <= '0;
      sel_q       <= '0;
      coin_reject <= 1'b0;
      err_funds   <= 1'b0;
      err_soldout <= 1'b0;
    end else begin
      state       <= state_d;
      balance     <= balance_d;
      change      <= change_d;
      sel_q       <= sel_d;
      coin_reject <= coin_reject_d;
      err_funds   <= err_funds_d;
      err_soldout <= err_soldout_d;
    end
  end

  // Next-state logic; any coin that is not credited is returned via coin_reject.
  always_comb begin
    state_d       = state;
    balance_d     = balance;
    change_d      = change;
    sel_d         = sel_q;
    coin_reject_d = 1'b0;
    err_funds_d   = 1'b0;
    err_soldout_d = 1'b0;
    case (state)
      COLLECT: begin
        if (cancel) begin
          coin_reject_d = (coin != COIN_NONE);
          if (balance != '0) begin
            change_d  = balance;
            balance_d = '0;
            state_d   = PAYOUT;
          end
        end else if (dispense) begin
          coin_reject_d = (coin != COIN_NONE);
          if (32'(sel) < N_ITEMS) begin
            if (sold_out[sel]) begin
              err_soldout_d = 1'b1;
            end else if (balance < price_sel) begin
              err_funds_d = 1'b1;
            end else begin
              sel_d   = sel;
              state_d = VEND;
            end
          end
        end else if (coin != COIN_NONE) begin
          if (coin_sum <= (BAL_W+1)'(MAX_BAL)) balance_d = coin_sum[BAL_W-1:0];
          else coin_reject_d = 1'b1;
        end
      end
      VEND: begin
        coin_reject_d = (coin != COIN_NONE);
        change_d      = balance - price_q;
        balance_d     = '0;
        state_d       = (change_d != '0) ? PAYOUT : COLLECT;
      end
      PAYOUT: begin
        coin_reject_d = (coin != COIN_NONE);
        if (change_ack) begin
          change_d = '0;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Vend strobe and payout-valid decoded from the state register.
  always_comb begin
    vend = '0;
    if (state == VEND) vend[sel_q] = 1'b1;
  end

  assign change_valid = (state == PAYOUT);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       dispense, cancel, restock, change_ack;
  logic [1:0] restock_sel;
  logic [9:0] balance, change;
  logic       change_valid, coin_reject, err_funds, err_soldout;
  logic [3:0] vend, sold_out;

  int tests = 0;
  int fails = 0;

  vend_ctrl #(
    .N_ITEMS    (4),
    .BAL_W      (10),
    .MAX_BAL    (500),
    .PRICES     ({10'd100, 10'd200, 10'd250, 10'd150}),
    .STOCK_W    (4),
    .STOCK_INIT (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin         (coin),
    .sel          (sel),
    .dispense     (dispense),
    .cancel       (cancel),
    .restock      (restock),
    .restock_sel  (restock_sel),
    .change_ack   (change_ack),
    .balance      (balance),
    .change       (change),
    .change_valid (change_valid),
    .vend         (vend),
    .coin_reject  (coin_reject),
    .err_funds    (err_funds),
    .err_soldout  (err_soldout),
    .sold_out     (sold_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    coin = 2'b00; dispense = 1'b0; cancel = 1'b0; restock = 1'b0; change_ack = 1'b0;
  endtask

  // Buy item 2 (price 200) with one 200 coin; expects an exact-change vend.
  task automatic buy2(input string tag);
    coin = 2'b11; tick(); coin = 2'b00;
    chk({tag, "_bal"}, 32'(balance), 200);
    dispense = 1'b1; sel = 2'd2; tick(); dispense = 1'b0;
    chk({tag, "_vend"}, 32'(vend), 32'b0100);
    tick();
    chk({tag, "_nopay"}, 32'(change_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 2'd0; restock_sel = 2'd0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_balance", 32'(balance), 0);
    chk("rst_cv", 32'(change_valid), 0);
    chk("rst_vend", 32'(vend), 0);
    chk("rst_soldout", 32'(sold_out), 0);
    chk("rst_reject", 32'(coin_reject), 0);

    // Cola with change: 300 in, price 250, change 50
    repeat (3) begin coin = 2'b10; tick(); end
    coin = 2'b00;
    chk("cola_bal", 32'(balance), 300);
    dispense = 1'b1; sel = 2'd1; tick(); dispense = 1'b0;
    chk("cola_vend", 32'(vend), 32'b0010);
    tick();
    chk("cola_vend_off", 32'(vend), 0);
    chk("cola_cv", 32'(change_valid), 1);
    chk("cola_change", 32'(change), 50);
    chk("cola_bal0", 32'(balance), 0);
    tick();
    chk("cola_cv_hold", 32'(change_valid), 1);
    chk("cola_change_hold", 32'(change), 50);
    change_ack = 1'b1; tick(); change_ack = 1'b0;
    chk("cola_ack_cv", 32'(change_valid), 0);
    chk("cola_ack_change", 32'(change), 0);

    // Insufficient funds keeps the balance; then exact water purchase
    coin = 2'b10; tick(); coin = 2'b00;
    dispense = 1'b1; sel = 2'd1; tick(); dispense = 1'b0;
    chk("funds_err", 32'(err_funds), 1);
    chk("funds_bal", 32'(balance), 100);
    chk("funds_novend", 32'(vend), 0);
    tick();
    chk("funds_pulse", 32'(err_funds), 0);
    coin = 2'b01; tick(); coin = 2'b00;
    chk("water_bal", 32'(balance), 150);
    dispense = 1'b1; sel = 2'd0; tick(); dispense = 1'b0;
    chk("water_vend", 32'(vend), 32'b0001);
    tick();
    chk("water_nopay", 32'(change_valid), 0);
    chk("water_bal0", 32'(balance), 0);
    coin = 2'b01; tick(); coin = 2'b00;
    chk("water_collect", 32'(balance), 50);
    cancel = 1'b1; tick(); cancel = 1'b0;
    change_ack = 1'b1; tick(); change_ack = 1'b0;

    // Ceiling at 500
    coin = 2'b11; tick(); coin = 2'b11; tick(); coin = 2'b10; tick();
    chk("ceil_bal", 32'(balance), 500);
    chk("ceil_noreject", 32'(coin_reject), 0);
    coin = 2'b01; tick(); coin = 2'b00;
    chk("ceil_reject", 32'(coin_reject), 1);
    chk("ceil_hold", 32'(balance), 500);
    tick();
    chk("ceil_pulse", 32'(coin_reject), 0);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("ceil_refund", 32'(change), 500);
    change_ack = 1'b1; tick(); change_ack = 1'b0;

    // Cancel with a coin arriving in the same cycle
    coin = 2'b10; tick(); coin = 2'b01; tick();
    chk("cancel_bal", 32'(balance), 150);
    cancel = 1'b1; coin = 2'b10; tick(); cancel = 1'b0; coin = 2'b00;
    chk("cancel_reject", 32'(coin_reject), 1);
    chk("cancel_cv", 32'(change_valid), 1);
    chk("cancel_change", 32'(change), 150);
    chk("cancel_bal0", 32'(balance), 0);
    coin = 2'b10; tick(); coin = 2'b00;
    chk("payout_coin_reject", 32'(coin_reject), 1);
    chk("payout_coin_bal", 32'(balance), 0);
    change_ack = 1'b1; tick(); change_ack = 1'b0;
    chk("cancel_ack_cv", 32'(change_valid), 0);

    // Sold out on item 2 after eight vends
    for (int i = 0; i < 8; i++) begin
      buy2("sold");
      if (i < 7) chk("sold_early", 32'(sold_out), 0);
    end
    chk("sold_flag", 32'(sold_out), 32'b0100);
    coin = 2'b11; tick(); coin = 2'b00;
    dispense = 1'b1; sel = 2'd2; tick(); dispense = 1'b0;
    chk("sold_err", 32'(err_soldout), 1);
    chk("sold_novend", 32'(vend), 0);
    chk("sold_bal", 32'(balance), 200);
    restock = 1'b1; restock_sel = 2'd2; tick(); restock = 1'b0;
    chk("restock_clear", 32'(sold_out), 0);
    chk("sold_err_pulse", 32'(err_soldout), 0);

    // Reset during payout
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("rstpay_cv", 32'(change_valid), 1);
    chk("rstpay_change", 32'(change), 200);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rstpay_cv0", 32'(change_valid), 0);
    chk("rstpay_change0", 32'(change), 0);
    chk("rstpay_bal0", 32'(balance), 0);
    chk("rstpay_vend0", 32'(vend), 0);
    chk("rstpay_soldout", 32'(sold_out), 0);
    for (int i = 0; i < 8; i++) begin
      buy2("reinit");
      if (i < 7) chk("reinit_early", 32'(sold_out), 0);
    end
    chk("reinit_stock8", 32'(sold_out), 32'b0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
